// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: read-return owner tags and
// the arbiter FSM state encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_DMA  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_OWN   = 2'd1,
    DMA_OWN   = 2'd2,
    DMA_BURST = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return owner tag delay line: the tag pushed with a read grant
// emerges exactly RD_LAT cycles later, aligned with the memory read data.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t stage_q [RD_LAT];

  // NOTE: every stage is reset, so reads still in flight at reset never
  // surface as an rvalid after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) stage_q[i] <= TAG_NONE;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / DMA) arbiter in front of a single-port memory with
// round-robin ties, bounded DMA lock bursts and tagged read-data return.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t        state_q, state_d;
  owner_t            last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              grant_cpu, grant_dma;
  logic              burst_full;
  owner_t            tag_push, tag_out;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  assign burst_full = (burst_cnt_q == CNT_W'(MAX_BURST));

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    grant_cpu    = 1'b0;
    grant_dma    = 1'b0;
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;

    if (state_q == DMA_BURST) begin
      // Locked DMA wins ties until the burst is full, then a waiting CPU goes.
      if (burst_full && cpu_req) grant_cpu = 1'b1;
      else if (dma_req)          grant_dma = 1'b1;
      else if (cpu_req)          grant_cpu = 1'b1;
    end else if (cpu_req && dma_req) begin
      if (last_owner_q == TAG_CPU) grant_dma = 1'b1;
      else                         grant_cpu = 1'b1;
    end else begin
      grant_cpu = cpu_req;
      grant_dma = dma_req;
    end

    if (grant_cpu) begin
      state_d      = CPU_OWN;
      last_owner_d = TAG_CPU;
      burst_cnt_d  = '0;
    end else if (grant_dma) begin
      last_owner_d = TAG_DMA;
      if (dma_lock) begin
        state_d = DMA_BURST;
        if (!burst_full) burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end else begin
        state_d     = DMA_OWN;
        burst_cnt_d = '0;
      end
    end else begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end
  end

  // Grants are gated by reset so the memory bus goes quiet the moment
  // reset is asserted, not at the next edge.
  assign cpu_gnt = grant_cpu & rst_n;
  assign dma_gnt = grant_dma & rst_n;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_push  = TAG_NONE;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      tag_push  = cpu_we ? TAG_NONE : TAG_CPU;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      tag_push  = dma_we ? TAG_NONE : TAG_DMA;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= TAG_DMA;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_push),
    .tag_out (tag_out)
  );

  assign cpu_rvalid = (tag_out == TAG_CPU);
  assign dma_rvalid = (tag_out == TAG_DMA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dma_rvalid) dma_rdata_q <= mem_rdata;
    end
  end

  // Returned data is forwarded in the rvalid cycle and held afterwards.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = dma_rvalid ? mem_rdata : dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter lanes (RD_LAT = 1, 2, 3) share one set of
// requester inputs, each backed by its own fixed-latency memory model.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 8;
  localparam int NL = 3;
  localparam int NALT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic          dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;

  logic          cpu_gnt [NL];
  logic          dma_gnt [NL];
  logic          cpu_rvalid [NL];
  logic          dma_rvalid [NL];
  logic          mem_we [NL];
  logic [DW-1:0] cpu_rdata [NL];
  logic [DW-1:0] dma_rdata [NL];
  logic [DW-1:0] mem_wdata [NL];
  logic [DW-1:0] mem_rdata [NL];
  logic [AW-1:0] mem_addr [NL];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lane
    logic [DW-1:0] pipe_q [4] = '{default: '0};

    mem_port_arbiter #(
      .DATA_W(DW), .ADDR_W(AW), .RD_LAT(g + 1), .MAX_BURST(MB)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt[g]),
      .cpu_rvalid (cpu_rvalid[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_lock   (dma_lock),
      .dma_gnt    (dma_gnt[g]),
      .dma_rvalid (dma_rvalid[g]),
      .dma_rdata  (dma_rdata[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g])
    );

    // Memory returns mem_val(address) exactly g+1 cycles after presentation.
    always @(posedge clk) begin
      pipe_q[0] <= mem_val(mem_addr[g]);
      for (int i = 1; i < 4; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign mem_rdata[g] = pipe_q[g];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int l = 0; l < NL; l++) begin
      check($sformatf("%s L%0d cpu_gnt", tag, l), cpu_gnt[l], 0);
      check($sformatf("%s L%0d dma_gnt", tag, l), dma_gnt[l], 0);
      check($sformatf("%s L%0d cpu_rvalid", tag, l), cpu_rvalid[l], 0);
      check($sformatf("%s L%0d dma_rvalid", tag, l), dma_rvalid[l], 0);
      check($sformatf("%s L%0d mem_we", tag, l), mem_we[l], 0);
      check($sformatf("%s L%0d mem_addr", tag, l), mem_addr[l], 0);
      check($sformatf("%s L%0d mem_wdata", tag, l), mem_wdata[l], 0);
      check($sformatf("%s L%0d cpu_rdata", tag, l), cpu_rdata[l], 0);
      check($sformatf("%s L%0d dma_rdata", tag, l), dma_rdata[l], 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both requesters active: everything must stay quiet.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_1234; cpu_wdata = 32'h1111_2222;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_5678; dma_wdata = 32'h3333_4444;
    #2;
    check_zero("reset");
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    #10 rst_n = 1'b1;
    tick();

    // Single CPU read, zero-wait grant, data back after each lane's latency.
    cpu_req = 1'b1; cpu_addr = 32'h0040_0000; #1;
    check("A cpu_gnt", cpu_gnt[0], 1);
    check("A dma_gnt", dma_gnt[0], 0);
    check("A mem_addr", mem_addr[0], 32'h0040_0000);
    check("A mem_we", mem_we[0], 0);
    tick(); cpu_req = 1'b0; cpu_addr = '0; #1;
    check("A L0 cpu_rvalid", cpu_rvalid[0], 1);
    check("A L0 cpu_rdata", cpu_rdata[0], 32'h5A1A_C3C3);
    check("A L0 dma_rvalid", dma_rvalid[0], 0);
    check("A idle mem_we", mem_we[0], 0);
    check("A idle mem_addr", mem_addr[0], 0);
    check("A idle mem_wdata", mem_wdata[0], 0);
    tick(); #1;
    check("A L1 cpu_rvalid", cpu_rvalid[1], 1);
    check("A L1 cpu_rdata", cpu_rdata[1], 32'h5A1A_C3C3);
    check("A L0 rvalid pulse", cpu_rvalid[0], 0);
    check("A L0 rdata hold", cpu_rdata[0], 32'h5A1A_C3C3);
    tick(); #1;
    check("A L2 cpu_rvalid", cpu_rvalid[2], 1);
    check("A L2 cpu_rdata", cpu_rdata[2], 32'h5A1A_C3C3);
    check("A L2 dma_rvalid", dma_rvalid[2], 0);

    // Reset pulse clears held read data; CPU then wins the first tie.
    tick(); rst_n = 1'b0; #1;
    check("B reset rdata", cpu_rdata[0], 0);
    rst_n = 1'b1;
    tick();
    cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 32'hA000_0100; dma_addr = 32'hB000_0200; #1;
    check("B c0 cpu_gnt", cpu_gnt[0], 1);
    check("B c0 dma_gnt", dma_gnt[0], 0);
    check("B c0 mem_addr", mem_addr[0], 32'hA000_0100);
    tick(); cpu_req = 1'b0; #1;
    check("B c1 cpu_gnt", cpu_gnt[0], 0);
    check("B c1 dma_gnt", dma_gnt[0], 1);
    check("B c1 mem_addr", mem_addr[0], 32'hB000_0200);
    check("B c1 L0 cpu_rvalid", cpu_rvalid[0], 1);
    check("B c1 L0 cpu_rdata", cpu_rdata[0], 32'hFA5A_C2C3);
    check("B c1 L0 dma_rvalid", dma_rvalid[0], 0);
    tick(); dma_req = 1'b0; dma_addr = '0; cpu_addr = '0; #1;
    check("B c2 L0 dma_rvalid", dma_rvalid[0], 1);
    check("B c2 L0 dma_rdata", dma_rdata[0], 32'hEA5A_C1C3);
    check("B c2 L0 cpu_rvalid", cpu_rvalid[0], 0);
    check("B c2 L1 cpu_rvalid", cpu_rvalid[1], 1);
    tick(); #1;
    check("B c3 L1 dma_rvalid", dma_rvalid[1], 1);
    check("B c3 L1 dma_rdata", dma_rdata[1], 32'hEA5A_C1C3);
    check("B c3 L2 cpu_rvalid", cpu_rvalid[2], 1);
    check("B c3 L2 cpu_rdata", cpu_rdata[2], 32'hFA5A_C2C3);
    tick(); #1;
    check("B c4 L2 dma_rvalid", dma_rvalid[2], 1);
    check("B c4 L2 cpu_rvalid", cpu_rvalid[2], 0);

    // DMA write drives the bus in the grant cycle and returns nothing.
    tick();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h1000_0010; dma_wdata = 32'hDEAD_BEEF; #1;
    check("C dma_gnt", dma_gnt[0], 1);
    check("C cpu_gnt", cpu_gnt[0], 0);
    check("C mem_we", mem_we[0], 1);
    check("C mem_addr", mem_addr[0], 32'h1000_0010);
    check("C mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);
    tick(); dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    for (int k = 0; k < NL; k++) begin
      #1;
      check($sformatf("C L%0d dma_rvalid", k), dma_rvalid[k], 0);
      check($sformatf("C L%0d cpu_rvalid", k), cpu_rvalid[k], 0);
      tick();
    end

    // Locked DMA burst against a persistent CPU: 1 cpu, then (8 dma, 1 cpu)...
    cpu_req = 1'b1; cpu_we = 1'b1; dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1;
    for (int c = 0; c < 19; c++) begin
      #1;
      check($sformatf("E c%0d cpu_gnt", c), cpu_gnt[0], (c % 9 == 0) ? 1 : 0);
      check($sformatf("E c%0d dma_gnt", c), dma_gnt[0], (c % 9 == 0) ? 0 : 1);
      tick();
    end
    cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0;
    tick();

    // Reset one cycle after a CPU read grant: output quiet at once, read lost.
    cpu_req = 1'b1; cpu_addr = 32'h0000_0ABC; #1;
    check("F cpu_gnt", cpu_gnt[1], 1);
    tick(); rst_n = 1'b0; #1;
    check_zero("F");
    cpu_req = 1'b0; cpu_addr = '0;
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("F c%0d L1 cpu_rvalid", c), cpu_rvalid[1], 0);
      check($sformatf("F c%0d L2 cpu_rvalid", c), cpu_rvalid[2], 0);
      tick();
    end

    // Back-to-back alternating reads: one return per cycle, correct owner.
    for (int c = 0; c < NALT + 4; c++) begin
      if (c < NALT) begin
        cpu_req = 1'b1; dma_req = 1'b1;
        cpu_addr = 32'h2000_0000 + c; dma_addr = 32'h3000_0000 + c;
      end else begin
        cpu_req = 1'b0; dma_req = 1'b0; cpu_addr = '0; dma_addr = '0;
      end
      #1;
      check($sformatf("G c%0d cpu_gnt", c), cpu_gnt[0], (c < NALT && c % 2 == 0) ? 1 : 0);
      check($sformatf("G c%0d dma_gnt", c), dma_gnt[0], (c < NALT && c % 2 == 1) ? 1 : 0);
      for (int l = 0; l < NL; l++) begin
        int k;
        k = c - (l + 1);
        if (k >= 0 && k < NALT) begin
          check($sformatf("G c%0d L%0d cpu_rvalid", c, l), cpu_rvalid[l], (k % 2 == 0) ? 1 : 0);
          check($sformatf("G c%0d L%0d dma_rvalid", c, l), dma_rvalid[l], (k % 2 == 1) ? 1 : 0);
          if (k % 2 == 0)
            check($sformatf("G c%0d L%0d cpu_rdata", c, l), cpu_rdata[l], mem_val(32'h2000_0000 + k));
          else
            check($sformatf("G c%0d L%0d dma_rdata", c, l), dma_rdata[l], mem_val(32'h3000_0000 + k));
        end else begin
          check($sformatf("G c%0d L%0d cpu_rvalid", c, l), cpu_rvalid[l], 0);
          check($sformatf("G c%0d L%0d dma_rvalid", c, l), dma_rvalid[l], 0);
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: DATA_W, default 32, data width; ADDR_W, default 32, byte-address width; RD_LAT, default 1, memory read latency in cycles (1..4); MAX_BURST, default 8, maximum consecutive locked DMA grants.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 cpu_req  in  1  CPU access request; held until cpu_gnt.
REQ-005 cpu_we  in  1  CPU write (1) / read (0).
REQ-006 cpu_addr  in  ADDR_W  CPU byte address.
REQ-007 cpu_wdata  in  DATA_W  CPU write data.
REQ-008 cpu_gnt  out  1  CPU access issued to memory this cycle.
REQ-009 cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse.
REQ-010 cpu_rdata  out  DATA_W  CPU read data.
REQ-011 dma_req, dma_we, dma_addr, dma_wdata, dma_lock  in  1/1/ADDR_W/DATA_W/1  second requester (loader/DMA) port; dma_lock asks to keep ownership across consecutive accesses.
REQ-012 dma_gnt, dma_rvalid, dma_rdata  out  1/1/DATA_W  same meaning as CPU counterparts.
REQ-013 mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  to single-port memory.
REQ-014 mem_rdata  in  DATA_W  from memory, valid RD_LAT cycles after a read is issued.

Function
REQ-015 At most one of cpu_gnt, dma_gnt SHALL be high in any cycle; grant is combinational from current requests and registered arbiter state.
REQ-016 Granted port's we/addr/wdata SHALL drive mem_* in the grant cycle; with no grant mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold 0.
REQ-017 Single requester SHALL be granted in the cycle it requests (zero-wait when bus free).
REQ-018 Simultaneous cpu_req and dma_req without active lock SHALL be resolved round-robin: the port not granted last wins; register last_owner updated on every grant.
REQ-019 FSM states: IDLE, CPU_OWN, DMA_OWN, DMA_BURST. DMA_BURST entered when dma granted with dma_lock=1; exited to IDLE when dma_lock=0, dma_req=0, or burst counter reaches MAX_BURST.
REQ-020 In DMA_BURST, dma SHALL win ties; burst counter increments per DMA grant, saturates at MAX_BURST; on reaching MAX_BURST with cpu_req=1, cpu SHALL receive the next grant and counter SHALL clear.
REQ-021 Burst counter SHALL clear on leaving DMA_BURST and on any CPU grant.
REQ-022 Each read grant SHALL push owner tag into an RD_LAT-deep shift pipeline; exactly RD_LAT cycles later the owner's rvalid pulses one cycle with rdata=mem_rdata; the other port's rvalid stays 0.
REQ-023 Write grants SHALL push a null tag; no rvalid results.
REQ-024 Back-to-back reads from alternating ports SHALL each return to the correct owner, one result per cycle, no bubbles.
REQ-025 cpu_rdata/dma_rdata SHALL hold last delivered value between rvalid pulses.
REQ-026 Request dropped before grant SHALL be treated as withdrawn; no state change.

Reset
REQ-027 reset low SHALL immediately force: gnt=0, rvalid=0, mem_we=0, rdata=0, state=IDLE, burst counter=0, tag pipeline cleared, last_owner=DMA (CPU wins first tie).
REQ-028 Reads in flight at reset SHALL be discarded; no rvalid after reset release.

Structure
REQ-029 Owner tag encoding (NONE, CPU, DMA) and FSM state enumeration SHALL live in a shared package mem_arb_pkg.
REQ-030 Read-return tag shift pipeline SHALL be sub-module rd_tag_pipe (parameter RD_LAT).

Verification
REQ-031 CPU read only, addr 0x0040_0000, RD_LAT=1 -> cpu_gnt same cycle, cpu_rvalid next cycle with mem_rdata, dma_rvalid=0.
REQ-032 cpu_req and dma_req high together from reset, both reads -> cpu granted cycle 0, dma cycle 1, rvalids cycles 1 and 2 to correct ports.
REQ-033 dma_lock=1, dma_req continuous, cpu_req=1 throughout, MAX_BURST=8 -> 8 dma_gnt then 1 cpu_gnt, repeating.
REQ-034 DMA write 0x1000_0010 data 0xDEAD_BEEF -> mem_we=1 with that address/data in grant cycle, no rvalid.
REQ-035 reset asserted one cycle after CPU read grant with RD_LAT=2 -> all outputs 0 immediately, no cpu_rvalid after release.
REQ-036 Random alternating reads from both ports, RD_LAT=3 -> scoreboard: every read returns exactly once to its owner in order, never two grants in one cycle.
